sum_uart_tx: RTL



---
 rtl/sum_uart_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: on a synchronised rising edge of uart_tx_en, captures sum_value and sends "DD\r\n" over UART.
// Framing is 8N1 by default; define SUM_UART_PARITY_EN for 8E1 (even parity bit after data bit 7).
module sum_uart_tx #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600,
  parameter int SUM_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SUM_W-1:0] sum_value,
  input  logic             uart_tx_en,
  output logic             uart_txd,
  output logic             uart_tx_busy
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SUM_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  // Character order of the message: tens digit, ones digit, CR, LF.
  function automatic logic [7:0] char_sel(input logic [1:0] idx,
                                          input logic [3:0] tens,
                                          input logic [3:0] ones);
    case (idx)
      2'd0:    char_sel = 8'h30 + {4'h0, tens};
      2'd1:    char_sel = 8'h30 + {4'h0, ones};
      2'd2:    char_sel = 8'h0D;
      2'd3:    char_sel = 8'h0A;
      default: char_sel = 8'h0A;
    endcase
  endfunction

`ifdef SUM_UART_PARITY_EN
  function automatic logic parity_even(input logic [7:0] data);
    parity_even = ^data;
  endfunction
`endif

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [1:0]       char_idx_r, char_idx_s;
  logic [3:0]       tens_r, tens_s, ones_r, ones_s;
  logic             txd_r, txd_s, busy_r, busy_s;
  logic             sync1_r, sync2_r, sync3_r, edge_r;
  logic [6:0]       sum_ext_s;
  logic [7:0]       cur_char_s;
  logic             bit_done_s;

  assign sum_ext_s    = 7'(sum_value);
  assign cur_char_s   = char_sel(char_idx_r, tens_r, ones_r);
  assign bit_done_s   = (cnt_r == CNT_LAST);
  assign uart_txd     = txd_r;
  assign uart_tx_busy = busy_r;

  // Request synchroniser; the edge pulse is registered so capture happens on the 4th clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= uart_tx_en;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      edge_r  <= sync2_r & ~sync3_r;
    end
  end

  // Next-state and next-output logic; the line value is registered one step ahead of each bit.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    char_idx_s = char_idx_r;
    tens_s     = tens_r;
    ones_s     = ones_r;
    txd_s      = txd_r;
    busy_s     = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_r) begin
          tens_s     = 4'(sum_ext_s / 7'd10);
          ones_s     = 4'(sum_ext_s % 7'd10);
          busy_s     = 1'b1;
          txd_s      = 1'b0;
          cnt_s      = '0;
          bit_idx_s  = 3'd0;
          char_idx_s = 2'd0;
          state_s    = ST_START;
        end else begin
          txd_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          cnt_s     = '0;
          bit_idx_s = 3'd0;
          txd_s     = cur_char_s[0];
          state_s   = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cnt_s = '0;
          if (bit_idx_r == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
            txd_s   = parity_even(cur_char_s);
            state_s = ST_PARITY;
`else
            txd_s   = 1'b1;
            state_s = ST_STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            txd_s     = cur_char_s[bit_idx_r + 3'd1];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef SUM_UART_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          cnt_s   = '0;
          txd_s   = 1'b1;
          state_s = ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          cnt_s = '0;
          if (char_idx_r == 2'd3) begin
            busy_s  = 1'b0;
            txd_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            char_idx_s = char_idx_r + 2'd1;
            txd_s      = 1'b0;
            state_s    = ST_START;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        txd_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Transmitter state and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      char_idx_r <= 2'd0;
      tens_r     <= 4'd0;
      ones_r     <= 4'd0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      char_idx_r <= char_idx_s;
      tens_r     <= tens_s;
      ones_r     <= ones_s;
      txd_r      <= txd_s;
      busy_r     <= busy_s;
    end
  end

endmodule
